// File: rtl/ofs_jtag_if.sv
// JTAG pin bundle between a scan master (source) and a TAP chain (sink).
interface ofs_jtag_if;
    logic tck;
    logic tckena;
    logic tms;
    logic tdi;
    logic tdo;

    modport source (output tck, output tckena, output tms, output tdi, input tdo);
    modport sink   (input tck, input tckena, input tms, input tdi, output tdo);
endinterface

// File: rtl/ofs_jtag_master_ctrl.sv
// Host-side JTAG sequencer: turns queued scan commands into divided TCK cycles,
// walks the TAP, shifts TDI LSB-first and returns the captured TDO.
module ofs_jtag_master_ctrl #(
    parameter int DIV     = 2,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    ofs_jtag_if.source         jtag
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_IR        = 2'd1;
    localparam logic [1:0] OP_DR        = 2'd2;
    localparam logic [1:0] OP_RUN_IDLE  = 2'd3;

    localparam logic [LEN_W-1:0] L1 = LEN_W'(1);
    localparam logic [LEN_W-1:0] L5 = LEN_W'(5);

    typedef enum logic [2:0] {TLR_INIT, IDLE, PRE, SHIFT, POST, RESP} state_t;

    state_t             state, state_n, adv_state;
    logic [LEN_W-1:0]   cnt, cnt_n, adv_cnt;
    logic [DIV_W-1:0]   divcnt, divcnt_n;
    logic               tck, tck_n, tckena, tckena_n, tms, tms_n, tdi, tdi_n;
    logic [1:0]         op, op_n;
    logic [LEN_W-1:0]   len, len_n, len_clamped, pre_last;
    logic [MAX_LEN-1:0] data, data_n, rsp_data_n;
    logic               rsp_valid_n, tick, launch;

    // TMS/TDI for TCK cycle c of a state; applied at the start of its low phase.
    function automatic logic [1:0] pin_values(input state_t st, input logic [LEN_W-1:0] c,
                                              input logic [1:0] o, input logic [LEN_W-1:0] l,
                                              input logic [MAX_LEN-1:0] d);
        logic t;
        logic i;
        t = 1'b0;
        i = 1'b0;
        case (st)
            TLR_INIT: t = (c < L5);
            PRE: begin
                case (o)
                    OP_IR:   t = (c < LEN_W'(2));
                    OP_DR:   t = (c == '0);
                    default: t = (c < L5);
                endcase
            end
            SHIFT: begin
                if (o != OP_RUN_IDLE) begin
                    t = (c == l - L1);
                    i = d[c[IDX_W-1:0]];
                end
            end
            POST:    t = (c == '0);
            default: t = 1'b0;
        endcase
        return {t, i};
    endfunction

    assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign pre_last    = (op == OP_TAP_RESET) ? L5 : (op == OP_IR) ? LEN_W'(3) : LEN_W'(2);
    assign tick        = (divcnt == DIV_W'(DIV - 1));

    // Where the sequence goes once the current TCK cycle's high phase completes.
    always_comb begin
        adv_state = state;
        adv_cnt   = cnt + L1;
        case (state)
            TLR_INIT: if (cnt == L5) adv_state = IDLE;
            PRE: begin
                if (cnt == pre_last) begin
                    adv_state = (op == OP_TAP_RESET) ? RESP : SHIFT;
                    adv_cnt   = '0;
                end
            end
            SHIFT: begin
                if (cnt == len - L1) begin
                    adv_state = (op == OP_RUN_IDLE) ? RESP : POST;
                    adv_cnt   = '0;
                end
            end
            POST:    if (cnt == L1) adv_state = RESP;
            default: adv_state = state;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        divcnt_n    = divcnt;
        tck_n       = tck;
        tckena_n    = tckena;
        tms_n       = tms;
        tdi_n       = tdi;
        op_n        = op;
        len_n       = len;
        data_n      = data;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        launch      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n       = cmd_op;
                    len_n      = len_clamped;
                    data_n     = cmd_data;
                    rsp_data_n = '0;
                    cnt_n      = '0;
                    if (cmd_op == OP_TAP_RESET)      state_n = PRE;
                    else if (len_clamped == '0)      state_n = RESP;
                    else if (cmd_op == OP_RUN_IDLE)  state_n = SHIFT;
                    else                             state_n = PRE;
                    if (state_n == RESP) rsp_valid_n = 1'b1;
                    else                 launch      = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                if (!tckena) begin
                    launch = 1'b1;
                end else if (!tick) begin
                    divcnt_n = divcnt + DIV_W'(1);
                end else if (!tck) begin
                    tck_n    = 1'b1;
                    divcnt_n = '0;
                    if (state == SHIFT && op != OP_RUN_IDLE)
                        rsp_data_n[cnt[IDX_W-1:0]] = jtag.tdo;
                end else begin
                    state_n  = adv_state;
                    cnt_n    = adv_cnt;
                    divcnt_n = '0;
                    tck_n    = 1'b0;
                    if (adv_state == RESP || adv_state == IDLE) begin
                        tckena_n    = 1'b0;
                        rsp_valid_n = (adv_state == RESP);
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
        endcase
        if (launch) begin
            tck_n          = 1'b0;
            tckena_n       = 1'b1;
            divcnt_n       = '0;
            {tms_n, tdi_n} = pin_values(state_n, cnt_n, op_n, len_n, data_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TLR_INIT;
            cnt       <= '0;
            divcnt    <= '0;
            tck       <= 1'b0;
            tckena    <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            op        <= OP_TAP_RESET;
            len       <= '0;
            data      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            divcnt    <= divcnt_n;
            tck       <= tck_n;
            tckena    <= tckena_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            op        <= op_n;
            len       <= len_n;
            data      <= data_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign jtag.tck    = tck;
    assign jtag.tckena = tckena;
    assign jtag.tms    = tms;
    assign jtag.tdi    = tdi;
endmodule

// File: tb/tb_ofs_jtag_master_ctrl.sv
// Self-checking bench: a behavioural TAP model on the pins plus a response scoreboard.
module tb_ofs_jtag_master_ctrl;
    localparam int DIV     = 2;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    ofs_jtag_if jif();

    ofs_jtag_master_ctrl #(.DIV(DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .jtag      (jif)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR} tap_t;

    tap_t        tap       = TLR;
    logic [63:0] sreg      = '0;
    logic [63:0] shifted   = '0;
    logic [63:0] tms_hist  = '0;
    logic [63:0] tdi_hist  = '0;
    logic [63:0] dr_cap    = '0;
    logic        loopback  = 1'b0;
    int          nshift    = 0;
    int          rises     = 0;
    int          checks    = 0;
    int          errors    = 0;
    logic [63:0] sb[$];

    assign jif.tdo = loopback ? jif.tdi : sreg[0];

    function automatic tap_t tapNext(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDDR : PAUDR;
            PAUDR:   return m ? EX2DR : PAUDR;
            EX2DR:   return m ? UPDDR : SHDR;
            UPDDR:   return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPDIR : PAUIR;
            PAUIR:   return m ? EX2IR : PAUIR;
            EX2IR:   return m ? UPDIR : SHIR;
            UPDIR:   return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    // TAP model: capture/shift act on the state held before this TCK rise.
    always @(posedge jif.tck) begin
        rises++;
        tms_hist = {tms_hist[62:0], jif.tms};
        tdi_hist = {tdi_hist[62:0], jif.tdi};
        case (tap)
            CAPDR: begin sreg = dr_cap; nshift = 0; shifted = '0; end
            CAPIR: begin sreg = '0;     nshift = 0; shifted = '0; end
            SHDR, SHIR: begin
                if (nshift < 64) shifted[nshift] = jif.tdi;
                sreg = {jif.tdi, sreg[63:1]};
                nshift++;
            end
            default: ;
        endcase
        tap = tapNext(tap, jif.tms);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sendCmd(input logic [1:0] op, input int len, input logic [63:0] data);
        logic rdy;
        int   waited;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        waited    = 0;
        do begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            waited++;
        end while (!rdy && waited < 200);
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", 64'(rdy), 64'd1);
    endtask

    task automatic waitRsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("rsp_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] op, input int len,
                                 input logic [63:0] data, input logic [63:0] expected,
                                 input int exptck, input logic [63:0] exptms);
        int          lat;
        int          r0;
        logic [63:0] mask;
        sb.push_back(expected);
        r0 = rises;
        sendCmd(op, len, data);
        waitRsp(lat);
        mask = (exptck >= 64) ? '1 : ((64'd1 << exptck) - 64'd1);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exptck * 2 * DIV));
        checkOutput({tag, "_tck"}, 64'(rises - r0), 64'(exptck));
        checkOutput({tag, "_tms"}, tms_hist & mask, exptms);
        checkOutput({tag, "_rsp"}, rsp_data, sb.pop_front());
        @(posedge clk); #1;
        checkOutput({tag, "_done"}, {61'd0, rsp_valid, cmd_ready, busy}, 64'h2);
        checkOutput({tag, "_tap"}, 64'(tap), 64'(RTI));
    endtask

    task automatic tlrCheck(input string tag);
        int   n;
        int   r0;
        logic seen;
        r0   = rises;
        n    = 0;
        seen = 1'b0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput({tag, "_busy_clk"}, 64'(n - 1), 64'(6 * 2 * DIV));
        checkOutput({tag, "_tck"}, 64'(rises - r0), 64'd6);
        checkOutput({tag, "_tms"}, tms_hist & 64'h3F, 64'h3E);
        checkOutput({tag, "_idle"}, {61'd0, cmd_ready, jif.tckena, jif.tck}, 64'h4);
        checkOutput({tag, "_no_rsp"}, 64'(seen), 64'd0);
        checkOutput({tag, "_tap"}, 64'(tap), 64'(RTI));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        int          bad;
        int          r1;
        int          n;
        logic [63:0] held;
        logic [63:0] rnd_data;
        logic [63:0] rnd_cap;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", {57'd0, cmd_ready, rsp_valid, busy, jif.tck, jif.tckena, jif.tms, jif.tdi}, 64'h12);
        checkOutput("reset_rsp_data", rsp_data, 64'd0);
        rst_n = 1'b1;
        tlrCheck("init");

        loopback = 1'b1;
        applyStimulus("ir10", 2'd1, 10, 64'h2A5, 64'h2A5, 16, 64'hC006);
        checkOutput("ir10_tdi_order", shifted, 64'h2A5);
        checkOutput("ir10_nshift", 64'(nshift), 64'd10);
        loopback = 1'b0;

        dr_cap = 64'h1234_5678;
        applyStimulus("dr32", 2'd2, 32, 64'hDEAD_BEEF, 64'h1234_5678, 37, 64'h10_0000_0006);
        checkOutput("dr32_tdi", shifted, 64'hDEAD_BEEF);

        // Backpressure: response held while a new command waits.
        dr_cap    = 64'hC3;
        rsp_ready = 1'b0;
        sb.push_back(64'hC3);
        sendCmd(2'd2, 8, 64'h5A);
        waitRsp(lat);
        checkOutput("bp_lat", 64'(lat), 64'(13 * 2 * DIV));
        held      = rsp_data;
        cmd_op    = 2'd3;
        cmd_len   = LEN_W'(5);
        cmd_data  = '1;
        cmd_valid = 1'b1;
        bad       = 0;
        r1        = rises;
        repeat (10) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== held || cmd_ready || jif.tckena) bad++;
        end
        checkOutput("bp_hold", 64'(bad), 64'd0);
        checkOutput("bp_no_tck", 64'(rises - r1), 64'd0);
        checkOutput("bp_rsp", rsp_data, sb.pop_front());
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release", {62'd0, rsp_valid, cmd_ready}, 64'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("bp_accept", {61'd0, cmd_ready, busy, jif.tckena}, 64'h3);
        sb.push_back(64'd0);
        waitRsp(lat);
        checkOutput("bp_idle_lat", 64'(lat), 64'(5 * 2 * DIV));
        checkOutput("bp_idle_tck", 64'(rises - r1), 64'd5);
        checkOutput("bp_idle_tms", tms_hist & 64'h1F, 64'd0);
        checkOutput("bp_idle_rsp", rsp_data, sb.pop_front());
        @(posedge clk); #1;

        applyStimulus("dr0", 2'd2, 0, 64'hFFFF, 64'd0, 0, 64'd0);

        rnd_data = {$urandom, $urandom};
        rnd_cap  = {$urandom, $urandom};
        dr_cap   = rnd_cap;
        applyStimulus("dr100", 2'd2, 100, rnd_data, rnd_cap, 69, 64'h6);
        checkOutput("dr100_tdi", shifted, rnd_data);
        checkOutput("dr100_nshift", 64'(nshift), 64'd64);

        applyStimulus("idle5", 2'd3, 5, '1, 64'd0, 5, 64'd0);
        checkOutput("idle5_tdi", tdi_hist & 64'h1F, 64'd0);

        applyStimulus("tapreset", 2'd0, 0, 64'd0, 64'd0, 6, 64'h3E);

        // Asynchronous abort in the middle of a DR shift.
        dr_cap = 64'hFFFF_0000_AAAA_5555;
        sendCmd(2'd2, 32, 64'hDEAD_BEEF);
        n = 0;
        while (!(tap == SHDR && nshift == 7) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_reach", 64'(nshift), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outs", {58'd0, jif.tck, jif.tckena, rsp_valid, jif.tms, cmd_ready, busy}, 64'h5);
        checkOutput("abort_rsp_data", rsp_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tlrCheck("abort");
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofs_jtag_master_ctrl.md
Name: ofs_jtag_master_ctrl

Overview:
- Host-side JTAG sequencer that drives the source modport of ofs_jtag_if.
- Accepts queued scan commands (TAP reset, IR scan, DR scan, run-idle), divides clk down to TCK, walks the TAP state machine and shifts TDI out LSB-first.
- Captures TDO and returns it on a response channel.
- Sits between an AFU/management CSR bridge and an on-board or remote JTAG chain.

Parameters:
- DIV, 2: TCK half-period in clk cycles; legal range >= 1.
- MAX_LEN, 64: maximum scan length in bits.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accept.
- cmd_op  input  2  0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=RUN_IDLE.
- cmd_len  input  LEN_W  scan bit count, or idle TCK count for RUN_IDLE.
- cmd_data  input  MAX_LEN  TDI bits; bit0 shifted first.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_data  output  MAX_LEN  captured TDO; bit i = i-th shifted bit.
- busy  output  1  sequence in progress (includes post-reset TLR).
- jtag  ofs_jtag_if.source  -  drives tms/tdi/tck/tckena, samples tdo.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1, jtag.tck=0, jtag.tckena=0, jtag.tms=1, jtag.tdi=0. Async assertion forces these immediately, mid-operation included; the in-flight command and pending response are discarded.
- TCK generation: each TCK cycle is DIV clk low then DIV clk high. tck is registered; tck=0 whenever tckena=0. tckena=1 only while a sequence runs.
- TMS/TDI update on the clk edge that starts the low phase. TDO is registered on the clk edge that drives tck 0->1.
- FSM states: TLR_INIT, IDLE, PRE, SHIFT, POST, RESP.
  - TLR_INIT: entered on reset release. 6 TCK cycles, TMS = 1,1,1,1,1,0. Leaves the TAP in Run-Test/Idle, then goes to IDLE.
  - IDLE: cmd_ready=1 and busy=0. A cmd_valid&cmd_ready handshake latches op/len/data.
  - PRE: IR TMS = 1,1,0,0; DR TMS = 1,0,0.
  - SHIFT: len TCK cycles. TDI = data[i]. TMS=0, except the last bit where TMS=1 (Exit1).
  - POST: TMS = 1,0 (Update, then Idle).
  - RESP: rsp_valid=1. rsp_data is held stable until rsp_ready, then return to IDLE.
- TAP_RESET: 6 cycles, TMS = 1,1,1,1,1,0.
- RUN_IDLE: len cycles with TMS=0, TDI=0.
- Both TAP_RESET and RUN_IDLE respond with rsp_data=0.
- TCK counts: IR = N+6, DR = N+5, TAP_RESET = 6, RUN_IDLE = N.
- Length rules:
  - len=0 for IR/DR/RUN_IDLE: no TCK activity; rsp_valid asserts the cycle after accept.
  - len>MAX_LEN is clamped to MAX_LEN.
  - rsp_data bits >= len are 0.
- cmd_ready=0 whenever the FSM is not IDLE. Only one command is outstanding; no command is accepted while rsp_valid=1.
- A rsp handshake and a new cmd_valid in the same cycle: the command is accepted the following cycle, when IDLE.
- After the last POST TCK high phase completes, tck returns low and tckena drops on the same edge that raises rsp_valid.

Test Plan:
- Reset release, DIV=2 -> busy=1 and cmd_ready=0 for 24 clk; TMS observed at TCK rises = 1,1,1,1,1,0; then cmd_ready=1, tckena=0, tck=0.
- IR_SCAN len=10, data=0x2A5, tdo looped to tdi -> TMS at rises = 1,1,0,0, nine 0s, 1, 1, 0; TDI bit order 1,0,1,0,0,1,0,1,0,1; rsp_data=0x2A5 after 16 TCK (64 clk).
- DR_SCAN len=32, data=0xDEADBEEF, TDO model returns 0x12345678 LSB-first -> 37 TCK; rsp_data=0x12345678; upper 32 bits 0.
- Backpressure: rsp_ready=0 for 10 clk after rsp_valid, cmd_valid held -> rsp_valid/rsp_data stable, cmd_ready=0, no TCK; rsp_ready=1 -> next command accepted one cycle later.
- Boundary lengths: DR len=0 -> no tck edges, rsp_valid next cycle with data 0. DR len=100 -> exactly 64 shift cycles (69 TCK). RUN_IDLE len=5 -> 5 TCK, TMS=0.
- rst_n low at shift bit 7 of a DR len=32 scan -> tck/tckena/rsp_valid go 0 and tms goes 1 asynchronously; after release the 6-cycle TLR replays; no rsp is issued for the aborted scan.
